// File: rtl/inv_aes_pkg.sv
// Shared constants and FSM state type for the inverse round-key sequencer.
package inv_aes_pkg;

    localparam int unsigned NUM_ROUNDS  = 10;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned KEY_WORDS   = 4 * (NUM_ROUNDS + 1);
    localparam int unsigned ROUND_KEY_W = 128;
    localparam int unsigned WCNT_W      = $clog2(KEY_WORDS);
    localparam int unsigned RIDX_W      = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_SETUP,
        S_FIRE,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/inv_key_store.sv
// Expanded-key register file: one word written per cycle, one full round key
// (four consecutive words, word 0 in the most significant slot) read by round index.
module inv_key_store
    import inv_aes_pkg::*;
#(
    parameter int unsigned N_WORDS = KEY_WORDS,
    parameter int unsigned DATA_W  = WORD_W
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [WCNT_W-1:0]     i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [RIDX_W-1:0]     i_round,
    output logic [4*DATA_W-1:0]   o_round_key
);

    logic [DATA_W-1:0] r_mem [N_WORDS];

    // Word write; contents are not reset, a full reload always precedes use.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Gather the four words of the selected round key, big-endian word order.
    always_comb begin
        o_round_key = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            o_round_key[(3 - k) * DATA_W +: DATA_W] = r_mem[{i_round, 2'(k)}];
        end
    end

endmodule

// File: rtl/inv_round_key_sequencer.sv
// Loads the expanded AES key word-serially, then replays the round keys from
// the last round down to round 0, one strobe per key, pacing each key on the
// rising edge of the downstream completion signal.
module inv_round_key_sequencer
    import inv_aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   keyWordValid,
    input  logic [WORD_W-1:0]      keyWord,
    input  logic                   startDecrypt,
    input  logic                   invRoundsDone,
    output logic [ROUND_KEY_W-1:0] newKey,
    output logic                   enableInvAddRoundKey,
    output logic [RIDX_W-1:0]      roundIdx,
    output logic                   keyLoaded,
    output logic                   busy,
    output logic                   keySeqDone
);

    state_t                 r_state;
    state_t                 w_next;
    logic [WCNT_W-1:0]      r_word_cnt;
    logic [RIDX_W-1:0]      r_round;
    logic [ROUND_KEY_W-1:0] r_key;
    logic [ROUND_KEY_W-1:0] w_store_key;
    logic                   r_loaded;
    logic                   r_strobe;
    logic                   r_done_q;
    logic                   w_we;
    logic                   w_last_word;
    logic                   w_start;
    logic                   w_done_rise;

    inv_key_store #(
        .N_WORDS (KEY_WORDS),
        .DATA_W  (WORD_W)
    ) u_store (
        .clk         (clk),
        .i_we        (w_we),
        .i_waddr     (r_word_cnt),
        .i_wdata     (keyWord),
        .i_round     (r_round),
        .o_round_key (w_store_key)
    );

    // Decode load/start qualifiers; a reload in READY takes priority over a start.
    always_comb begin
        w_we        = keyWordValid &&
                      (r_state == S_IDLE || r_state == S_LOAD || r_state == S_READY);
        w_last_word = (r_word_cnt == WCNT_W'(KEY_WORDS - 1));
        w_start     = (r_state == S_READY) && startDecrypt && !keyWordValid;
        w_done_rise = invRoundsDone && !r_done_q;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state and status outputs.
    always_comb begin
        w_next     = r_state;
        busy       = 1'b0;
        keySeqDone = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (keyWordValid) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (keyWordValid && w_last_word) begin
                    w_next = S_READY;
                end
            end
            S_READY: begin
                if (keyWordValid) begin
                    w_next = S_LOAD;
                end else if (startDecrypt) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP: begin
                busy   = 1'b1;
                w_next = S_FIRE;
            end
            S_FIRE: begin
                busy   = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (w_done_rise) begin
                    w_next = (r_round == '0) ? S_DONE : S_SETUP;
                end
            end
            S_DONE: begin
                keySeqDone = 1'b1;
                w_next     = S_READY;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Word counter, load flag, round index, key register, strobe and done-edge history.
    // The strobe is registered off FIRE so it trails the newKey update by a full cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt <= '0;
            r_loaded   <= 1'b0;
            r_round    <= '0;
            r_key      <= '0;
            r_strobe   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_done_q <= invRoundsDone;
            r_strobe <= (r_state == S_FIRE);
            if (w_we) begin
                r_word_cnt <= w_last_word ? '0 : r_word_cnt + WCNT_W'(1);
                r_loaded   <= w_last_word;
            end
            if (w_start) begin
                r_round <= RIDX_W'(NUM_ROUNDS);
            end else if (r_state == S_WAIT && w_done_rise && r_round != '0) begin
                r_round <= r_round - RIDX_W'(1);
            end
            if (r_state == S_SETUP) begin
                r_key <= w_store_key;
            end
        end
    end

    assign newKey               = r_key;
    assign enableInvAddRoundKey = r_strobe;
    assign roundIdx             = r_round;
    assign keyLoaded            = r_loaded;

endmodule

// File: tb/tb_inv_round_key_sequencer.sv
// Bench for inv_round_key_sequencer: FIPS-197 key expansion computed locally,
// a word-indexed model of the key store, and a responsive downstream model.
module tb_inv_round_key_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         keyWordValid;
    logic [31:0]  keyWord;
    logic         startDecrypt;
    logic         invRoundsDone;
    logic [127:0] newKey;
    logic         enableInvAddRoundKey;
    logic [3:0]   roundIdx;
    logic         keyLoaded;
    logic         busy;
    logic         keySeqDone;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]  fips_w      [44];
    logic [31:0]  model_store [44];
    logic [127:0] first_key, last_key;
    logic [3:0]   first_idx, last_idx;

    always #5 clk = ~clk;

    inv_round_key_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .keyWordValid         (keyWordValid),
        .keyWord              (keyWord),
        .startDecrypt         (startDecrypt),
        .invRoundsDone        (invRoundsDone),
        .newKey               (newKey),
        .enableInvAddRoundKey (enableInvAddRoundKey),
        .roundIdx             (roundIdx),
        .keyLoaded            (keyLoaded),
        .busy                 (busy),
        .keySeqDone           (keySeqDone)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00)
            for (int i = 1; i < 256; i++)
                if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand_fips();
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++)
            fips_w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = 4; i < 44; i++) begin
            t = fips_w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = rcon[7] ? ((rcon << 1) ^ 8'h1b) : (rcon << 1);
            end
            fips_w[i] = fips_w[i-4] ^ t;
        end
    endtask

    function automatic logic [127:0] model_key(input int r);
        return {model_store[4*r], model_store[4*r+1], model_store[4*r+2], model_store[4*r+3]};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // mode 0: FIPS words, 1: all ones, 2: random
    task automatic load_words(input int first, input int n, input int mode);
        logic [31:0] v;
        for (int i = first; i < first + n; i++) begin
            case (mode)
                0:       v = fips_w[i];
                1:       v = 32'hffffffff;
                default: v = $urandom;
            endcase
            keyWordValid   = 1'b1;
            keyWord        = v;
            model_store[i] = v;
            tick();
        end
        keyWordValid = 1'b0;
    endtask

    // Starts a sequence and plays the downstream role: each strobe queues one
    // completion, raised after a short random delay and held for 'hold' cycles.
    task automatic run_sequence(input int hold, input bit inject, input int abort_round,
                                output bit aborted);
        int  strobes, dones, hi_left, pending, delay_left, after_done, exp_r, first_cyc;
        bit  finished;
        strobes = 0; dones = 0; hi_left = 0; pending = 0; delay_left = 0;
        after_done = 0; exp_r = 10; first_cyc = -1; finished = 1'b0; aborted = 1'b0;
        startDecrypt = 1'b1;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            tick();
            startDecrypt = 1'b0;
            keyWordValid = 1'b0;
            if (cyc == 1) begin
                n_tests++;
                if (newKey !== model_key(10) || enableInvAddRoundKey !== 1'b0) begin
                    n_fail++;
                    $display("FAIL key_before_strobe: key=%h en=%b, required key=%h en=0",
                             newKey, enableInvAddRoundKey, model_key(10));
                end
            end
            if (enableInvAddRoundKey === 1'b1) begin
                strobes++;
                pending++;
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    first_key = newKey;
                    first_idx = roundIdx;
                    n_tests++;
                    if (cyc != 2) begin
                        n_fail++;
                        $display("FAIL strobe_latency: strobe at cycle %0d, required 2", cyc);
                    end
                end
                last_key = newKey;
                last_idx = roundIdx;
                n_tests++;
                if (exp_r < 0) begin
                    n_fail++;
                    $display("FAIL extra_strobe: strobe with idx=%0d after round 0, required none",
                             roundIdx);
                end else if (newKey !== model_key(exp_r) || roundIdx !== 4'(exp_r) ||
                             busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL round_key: key=%h idx=%0d busy=%b, required key=%h idx=%0d busy=1",
                             newKey, roundIdx, busy, model_key(exp_r), exp_r);
                end
                if (exp_r == abort_round) begin
                    aborted  = 1'b1;
                    finished = 1'b1;
                    continue;
                end
                exp_r--;
            end
            if (keySeqDone === 1'b1) begin
                dones++;
                after_done = 1;
                n_tests++;
                if (exp_r != -1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_timing: done with %0d rounds left busy=%b, required 0 left busy=0",
                             exp_r + 1, busy);
                end
            end else if (after_done > 0) begin
                after_done++;
                if (after_done > 8) finished = 1'b1;
            end
            if (hi_left > 0) begin
                hi_left--;
                if (hi_left == 0) invRoundsDone = 1'b0;
            end else if (pending > 0) begin
                if (delay_left > 0) delay_left--;
                else begin
                    invRoundsDone = 1'b1;
                    hi_left       = hold;
                    pending--;
                    delay_left    = $urandom_range(0, 2);
                end
            end
            if (inject && busy === 1'b1 && (cyc % 5) == 1) begin
                keyWordValid = 1'b1;
                keyWord      = $urandom;
                startDecrypt = 1'b1;
            end
        end
        invRoundsDone = 1'b0;
        keyWordValid  = 1'b0;
        startDecrypt  = 1'b0;
        if (abort_round >= 0) begin
            n_tests++;
            if (!aborted) begin
                n_fail++;
                $display("FAIL abort_point: round %0d never presented, required it", abort_round);
            end
        end else begin
            n_tests++;
            if (strobes != 11 || dones != 1) begin
                n_fail++;
                $display("FAIL sequence_count: strobes=%0d dones=%0d, required 11 and 1",
                         strobes, dones);
            end
            n_tests++;
            if (busy !== 1'b0 || keyLoaded !== 1'b1) begin
                n_fail++;
                $display("FAIL after_sequence: busy=%b loaded=%b, required 0 and 1", busy, keyLoaded);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({newKey, enableInvAddRoundKey, roundIdx, keyLoaded, busy, keySeqDone} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: key=%h en=%b idx=%0d loaded=%b busy=%b done=%b, required all 0",
                     newKey, enableInvAddRoundKey, roundIdx, keyLoaded, busy, keySeqDone);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fips_sequence();
        bit ab;
        logic [127:0] k10, k0;
        k10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        k0  = 128'h000102030405060708090a0b0c0d0e0f;
        load_words(0, 44, 0);
        n_tests++;
        if (keyLoaded !== 1'b1) begin
            n_fail++;
            $display("FAIL fips_loaded: keyLoaded=%b, required 1", keyLoaded);
        end
        run_sequence(1, 1'b0, -1, ab);
        n_tests++;
        if (first_key !== k10 || first_idx !== 4'd10) begin
            n_fail++;
            $display("FAIL fips_first: key=%h idx=%0d, required %h idx=10", first_key, first_idx, k10);
        end
        n_tests++;
        if (last_key !== k0 || last_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL fips_last: key=%h idx=%0d, required %h idx=0", last_key, last_idx, k0);
        end
    endtask

    task automatic test_pacing();
        bit ab;
        run_sequence(5, 1'b0, -1, ab);
    endtask

    task automatic test_ignored_while_busy();
        bit ab;
        logic [127:0] k0;
        k0 = 128'h000102030405060708090a0b0c0d0e0f;
        run_sequence(2, 1'b1, -1, ab);
        n_tests++;
        if (last_key !== k0) begin
            n_fail++;
            $display("FAIL store_untouched: round0=%h, required %h", last_key, k0);
        end
    endtask

    task automatic test_reload();
        bit ab;
        logic [127:0] kff;
        kff = '1;
        startDecrypt   = 1'b1;
        keyWordValid   = 1'b1;
        keyWord        = 32'hffffffff;
        model_store[0] = 32'hffffffff;
        tick();
        startDecrypt = 1'b0;
        n_tests++;
        if (keyLoaded !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_wins: loaded=%b busy=%b, required 0 and 0", keyLoaded, busy);
        end
        load_words(1, 43, 1);
        n_tests++;
        if (keyLoaded !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_done: keyLoaded=%b, required 1", keyLoaded);
        end
        run_sequence(3, 1'b0, -1, ab);
        n_tests++;
        if (first_key !== kff || last_key !== kff) begin
            n_fail++;
            $display("FAIL reload_keys: first=%h last=%h, required all ff", first_key, last_key);
        end
    endtask

    task automatic test_random();
        bit ab;
        load_words(0, 44, 2);
        run_sequence($urandom_range(1, 4), 1'b1, -1, ab);
    endtask

    task automatic test_premature_start();
        bit ab;
        int bad;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load_words(0, 43, 0);
        bad = 0;
        startDecrypt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (enableInvAddRoundKey !== 1'b0 || busy !== 1'b0 || keyLoaded !== 1'b0) bad++;
        end
        startDecrypt = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL premature_start: %0d cycles active/loaded with 43 words, required 0", bad);
        end
        load_words(43, 1, 0);
        n_tests++;
        if (keyLoaded !== 1'b1) begin
            n_fail++;
            $display("FAIL last_word_loads: keyLoaded=%b, required 1", keyLoaded);
        end
        run_sequence(1, 1'b0, -1, ab);
    endtask

    task automatic test_reset_mid_sequence();
        bit ab;
        int bad;
        run_sequence(2, 1'b0, 6, ab);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({newKey, enableInvAddRoundKey, roundIdx, keyLoaded, busy, keySeqDone} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: key=%h en=%b idx=%0d loaded=%b busy=%b done=%b, required all 0",
                     newKey, enableInvAddRoundKey, roundIdx, keyLoaded, busy, keySeqDone);
        end
        tick();
        rst = 1'b0;
        bad = 0;
        startDecrypt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (enableInvAddRoundKey !== 1'b0 || busy !== 1'b0) bad++;
        end
        startDecrypt = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL start_after_reset: %0d active cycles, required 0", bad);
        end
        load_words(0, 44, 0);
        run_sequence(1, 1'b0, -1, ab);
    endtask

    initial begin
        rst           = 1'b1;
        keyWordValid  = 1'b0;
        keyWord       = '0;
        startDecrypt  = 1'b0;
        invRoundsDone = 1'b0;
        expand_fips();
        test_reset();
        test_fips_sequence();
        test_pacing();
        test_ignored_while_busy();
        test_reload();
        test_random();
        test_premature_start();
        test_reset_mid_sequence();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
